// File: rtl/usb_ep_buf_ctrl_pkg.sv
// Shared types and default parameters for the USB endpoint buffer controller.
package usb_ep_buf_ctrl_pkg;

    localparam int unsigned DEF_DEPTH_LOG2 = 7;
    localparam int unsigned DEF_MAX_PKT    = 64;
    localparam int unsigned DEF_FLUSH_TMO  = 4096;

    // IN release FSM: HOLD keeps bytes from the core, SEND exposes one packet.
    typedef enum logic {
        HOLD = 1'b0,
        SEND = 1'b1
    } ep_state_e;

endpackage

// File: rtl/usb_ep_buf_ctrl_fifo.sv
// Synchronous show-ahead FIFO with explicit occupancy count and synchronous clear.
module usb_sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign push_ok = push_i & ~full_o & ~clr_i;
    assign pop_ok  = pop_i & ~empty_o & ~clr_i;
    // Head byte forced to zero while empty so the output is defined after reset.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointers and level; clear has priority, pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
            else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because reads are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/usb_ep_buf_ctrl.sv
// IN/OUT endpoint buffering for usb1_core: IN bytes are held until a packet is
// complete, flushed or timed out; OUT bytes are presented as a plain stream.
module usb_ep_buf_ctrl
    import usb_ep_buf_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int unsigned MAX_PKT    = DEF_MAX_PKT,
    parameter int unsigned FLUSH_TMO  = DEF_FLUSH_TMO
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  usb_rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_flush,
    output logic [7:0]            ep_in_data,
    input  logic                  ep_in_re,
    output logic                  ep_in_empty,
    input  logic [7:0]            ep_out_data,
    input  logic                  ep_out_we,
    output logic                  ep_out_full,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   in_level,
    output logic [DEPTH_LOG2:0]   out_level,
    input  logic                  err_clr,
    output logic                  ovf_err,
    output logic                  unf_err
);

    localparam int unsigned LW = DEPTH_LOG2 + 1;
    localparam int unsigned CW = $clog2(MAX_PKT + 1);
    localparam int unsigned TW = (FLUSH_TMO > 1) ? $clog2(FLUSH_TMO) : 1;

    ep_state_e     state_q, state_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          in_full, in_fifo_empty, out_empty;
    logic          in_pop, pkt_full, tmo_hit;

    assign in_pop      = ep_in_re & ~empty_q;
    assign in_ready    = ~in_full;
    assign out_valid   = ~out_empty;
    assign ep_in_empty = empty_q;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
    assign pkt_full    = (in_level >= LW'(MAX_PKT));
    assign tmo_hit     = (FLUSH_TMO != 0) && (timer_q == TW'(FLUSH_TMO - 1));

    // IN direction buffer: user pushes, core pops only released bytes.
    usb_sync_fifo #(.DW(8), .AW(DEPTH_LOG2)) u_in_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (usb_rst),
        .push_i  (in_valid),
        .pop_i   (in_pop),
        .din_i   (in_data),
        .dout_o  (ep_in_data),
        .empty_o (in_fifo_empty),
        .full_o  (in_full),
        .level_o (in_level)
    );

    // OUT direction buffer: core pushes, user pops; writes while full are dropped inside.
    usb_sync_fifo #(.DW(8), .AW(DEPTH_LOG2)) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (usb_rst),
        .push_i  (ep_out_we),
        .pop_i   (out_ready),
        .din_i   (ep_out_data),
        .dout_o  (out_data),
        .empty_o (out_empty),
        .full_o  (ep_out_full),
        .level_o (out_level)
    );

    // Release FSM, packet counter, hold timer and sticky error flags.
    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        empty_d   = empty_q;

        if (usb_rst) begin
            state_d   = HOLD;
            pkt_cnt_d = '0;
            timer_d   = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            empty_d   = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (in_fifo_empty)       timer_d = '0;
                    else if (FLUSH_TMO != 0) timer_d = timer_q + TW'(1);
                    // Nothing buffered means no trigger can start a zero-length packet.
                    if (!in_fifo_empty && (pkt_full || in_flush || tmo_hit)) begin
                        state_d   = SEND;
                        pkt_cnt_d = pkt_full ? CW'(MAX_PKT) : CW'(in_level);
                        timer_d   = '0;
                    end
                end
                SEND: begin
                    timer_d = '0;
                    if (in_pop) begin
                        pkt_cnt_d = pkt_cnt_q - CW'(1);
                        if (pkt_cnt_q == CW'(1)) state_d = HOLD;
                    end
                end
                default: state_d = HOLD;
            endcase
            empty_d = (state_d == HOLD) || (pkt_cnt_d == '0);

            // A new error event beats a same-cycle clear.
            if (ep_out_we && ep_out_full) ovf_d = 1'b1;
            else if (err_clr)             ovf_d = 1'b0;
            if (ep_in_re && empty_q)      unf_d = 1'b1;
            else if (err_clr)             unf_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= HOLD;
            pkt_cnt_q <= '0;
            timer_q   <= '0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
            timer_q   <= timer_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

endmodule

// File: tb/tb_usb_ep_buf_ctrl.sv
// Self-checking bench for usb_ep_buf_ctrl: a default-timeout instance plus a
// short-timeout instance sharing the same stimulus.
module tb_usb_ep_buf_ctrl;

    logic       clk = 1'b0, rst_n = 1'b0, usb_rst = 1'b0;
    logic       in_valid = 1'b0, in_flush = 1'b0, ep_in_re = 1'b0;
    logic       ep_out_we = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] in_data = 8'h00, ep_out_data = 8'h00;

    logic       in_ready, ep_in_empty, ep_out_full, out_valid, ovf_err, unf_err;
    logic [7:0] ep_in_data, out_data, in_level, out_level;
    logic       t_in_ready, t_ep_in_empty, t_ep_out_full, t_out_valid, t_ovf_err, t_unf_err;
    logic [7:0] t_ep_in_data, t_out_data, t_in_level, t_out_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] out_q [$];

    always #5 clk = ~clk;

    usb_ep_buf_ctrl dut (
        .clk_i(clk), .rst_i(rst_n), .usb_rst(usb_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_flush(in_flush),
        .ep_in_data(ep_in_data), .ep_in_re(ep_in_re), .ep_in_empty(ep_in_empty),
        .ep_out_data(ep_out_data), .ep_out_we(ep_out_we), .ep_out_full(ep_out_full),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_level(in_level), .out_level(out_level),
        .err_clr(err_clr), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    usb_ep_buf_ctrl #(.FLUSH_TMO(16)) dut_t (
        .clk_i(clk), .rst_i(rst_n), .usb_rst(usb_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(t_in_ready), .in_flush(in_flush),
        .ep_in_data(t_ep_in_data), .ep_in_re(ep_in_re), .ep_in_empty(t_ep_in_empty),
        .ep_out_data(ep_out_data), .ep_out_we(ep_out_we), .ep_out_full(t_ep_out_full),
        .out_data(t_out_data), .out_valid(t_out_valid), .out_ready(out_ready),
        .in_level(t_in_level), .out_level(t_out_level),
        .err_clr(err_clr), .ovf_err(t_ovf_err), .unf_err(t_unf_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dut;
        usb_rst = 1'b1;
        tick();
        usb_rst = 1'b0;
        exp_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({in_ready, ep_in_empty, ep_out_full, out_valid, ovf_err, unf_err} !== 6'b110000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 110000",
                {in_ready, ep_in_empty, ep_out_full, out_valid, ovf_err, unf_err});
        end
        n_cmp++;
        if ({in_level, out_level, ep_in_data, out_data} !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {in_level, out_level, ep_in_data, out_data});
        end
        n_cmp++;
        if ({t_in_ready, t_ep_in_empty, t_ep_out_full, t_out_valid, t_ovf_err, t_unf_err,
             t_in_level, t_out_level, t_ep_in_data, t_out_data} !== {6'b110000, 32'h0}) begin
            n_bad++; $display("FAIL reset_tmo_inst: got %b/%h expected 110000/0",
                {t_in_ready, t_ep_in_empty, t_ep_out_full, t_out_valid, t_ovf_err, t_unf_err},
                {t_in_level, t_out_level, t_ep_in_data, t_out_data});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_packet;
        int n = 0;
        logic [7:0] e;
        clear_dut();
        for (int i = 0; i < 64; i++) begin
            in_data = 8'(i); in_valid = 1'b1; exp_q.push_back(8'(i));
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (ep_in_empty !== 1'b1 || in_level !== 8'd64) begin
            n_bad++; $display("FAIL full_hold: got empty=%b level=%0d expected empty=1 level=64", ep_in_empty, in_level);
        end
        tick();
        n_cmp++;
        if (ep_in_empty !== 1'b0) begin
            n_bad++; $display("FAIL full_release: got empty=%b expected 0", ep_in_empty);
        end
        while (!ep_in_empty && exp_q.size() > 0 && n < 200) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (ep_in_data !== e) begin
                n_bad++; $display("FAIL full_data[%0d]: got %h expected %h", n, ep_in_data, e);
            end
            ep_in_re = 1'b1; tick(); n++;
        end
        ep_in_re = 1'b0;
        n_cmp++;
        if (n !== 64 || ep_in_empty !== 1'b1 || in_level !== 8'd0) begin
            n_bad++; $display("FAIL full_len: got n=%0d empty=%b level=%0d expected 64/1/0", n, ep_in_empty, in_level);
        end
    endtask

    task automatic test_timeout;
        int cnt = -1;
        int n = 0;
        logic [7:0] e;
        clear_dut();
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h40 + 8'(i); in_valid = 1'b1; exp_q.push_back(8'h40 + 8'(i));
            tick(); cnt++;
        end
        in_valid = 1'b0;
        while (t_ep_in_empty && cnt < 40) begin
            tick(); cnt++;
        end
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++; $display("FAIL tmo_latency: got %0d cycles expected 16", cnt);
        end
        while (!t_ep_in_empty && exp_q.size() > 0 && n < 40) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (t_ep_in_data !== e) begin
                n_bad++; $display("FAIL tmo_data[%0d]: got %h expected %h", n, t_ep_in_data, e);
            end
            ep_in_re = 1'b1; tick(); n++;
        end
        ep_in_re = 1'b0;
        tick(); tick();
        n_cmp++;
        if (n !== 10 || t_ep_in_empty !== 1'b1 || t_in_level !== 8'd0) begin
            n_bad++; $display("FAIL tmo_len: got n=%0d empty=%b level=%0d expected 10/1/0", n, t_ep_in_empty, t_in_level);
        end
    endtask

    task automatic test_flush;
        int n = 0;
        logic [7:0] e;
        clear_dut();
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i); in_valid = 1'b1; exp_q.push_back(8'hA0 + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (ep_in_empty !== 1'b1) begin
            n_bad++; $display("FAIL flush_prehold: got empty=%b expected 1", ep_in_empty);
        end
        in_flush = 1'b1; tick(); in_flush = 1'b0;
        n_cmp++;
        if (ep_in_empty !== 1'b0) begin
            n_bad++; $display("FAIL flush_release: got empty=%b expected 0", ep_in_empty);
        end
        while (!ep_in_empty && exp_q.size() > 0 && n < 20) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (ep_in_data !== e) begin
                n_bad++; $display("FAIL flush_data[%0d]: got %h expected %h", n, ep_in_data, e);
            end
            ep_in_re = 1'b1; tick(); n++;
        end
        ep_in_re = 1'b0;
        n_cmp++;
        if (n !== 5) begin
            n_bad++; $display("FAIL flush_len: got %0d expected 5", n);
        end
        in_flush = 1'b1; tick(); in_flush = 1'b0;
        tick();
        n_cmp++;
        if (ep_in_empty !== 1'b1 || in_level !== 8'd0) begin
            n_bad++; $display("FAIL flush_zero_len: got empty=%b level=%0d expected 1/0", ep_in_empty, in_level);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int cnt = 0;
        logic [7:0] e;
        clear_dut();
        for (int i = 0; i < 70; i++) begin
            in_data = 8'(i); in_valid = 1'b1; exp_q.push_back(8'(i));
            tick();
        end
        in_valid = 1'b0;
        while (!ep_in_empty && exp_q.size() > 0 && n < 100) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (ep_in_data !== e) begin
                n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", n, ep_in_data, e);
            end
            ep_in_re = 1'b1; tick(); n++;
        end
        ep_in_re = 1'b0;
        n_cmp++;
        if (n !== 64 || in_level !== 8'd6 || ep_in_empty !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first_pkt: got n=%0d level=%0d empty=%b expected 64/6/1", n, in_level, ep_in_empty);
        end
        while (ep_in_empty && cnt < 5000) begin
            tick(); cnt++;
        end
        n_cmp++;
        if (cnt !== 4096) begin
            n_bad++; $display("FAIL b2b_tmo: got %0d cycles expected 4096", cnt);
        end
        n = 0;
        while (!ep_in_empty && exp_q.size() > 0 && n < 20) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (ep_in_data !== e) begin
                n_bad++; $display("FAIL b2b_tail[%0d]: got %h expected %h", n, ep_in_data, e);
            end
            ep_in_re = 1'b1; tick(); n++;
        end
        ep_in_re = 1'b0;
        n_cmp++;
        if (n !== 6 || ep_in_empty !== 1'b1) begin
            n_bad++; $display("FAIL b2b_tail_len: got n=%0d empty=%b expected 6/1", n, ep_in_empty);
        end
    endtask

    task automatic test_out_overflow;
        int n = 0;
        logic [7:0] e;
        clear_dut();
        out_ready = 1'b0;
        for (int i = 0; i <= 128; i++) begin
            if (i == 128) begin
                n_cmp++;
                if (ep_out_full !== 1'b1 || out_level !== 8'd128 || ovf_err !== 1'b0) begin
                    n_bad++; $display("FAIL out_full: got full=%b level=%0d ovf=%b expected 1/128/0", ep_out_full, out_level, ovf_err);
                end
            end
            ep_out_data = 8'(i); ep_out_we = 1'b1;
            if (i < 128) out_q.push_back(8'(i));
            tick();
        end
        ep_out_we = 1'b0;
        n_cmp++;
        if (ovf_err !== 1'b1 || out_level !== 8'd128) begin
            n_bad++; $display("FAIL out_ovf: got ovf=%b level=%0d expected 1/128", ovf_err, out_level);
        end
        out_ready = 1'b1;
        while (out_valid && out_q.size() > 0 && n < 300) begin
            e = out_q.pop_front();
            n_cmp++;
            if (out_data !== e) begin
                n_bad++; $display("FAIL out_data[%0d]: got %h expected %h", n, out_data, e);
            end
            tick(); n++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (n !== 128 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL out_drain: got n=%0d valid=%b expected 128/0", n, out_valid);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++;
        if (ovf_err !== 1'b0) begin
            n_bad++; $display("FAIL out_ovf_clr: got %b expected 0", ovf_err);
        end
    endtask

    task automatic test_usb_rst;
        int n = 0;
        logic [7:0] e;
        clear_dut();
        for (int i = 0; i < 40; i++) begin
            in_data = 8'hC0 ^ 8'(i); in_valid = 1'b1; exp_q.push_back(8'hC0 ^ 8'(i));
            tick();
        end
        in_valid = 1'b0;
        in_flush = 1'b1; tick(); in_flush = 1'b0;
        while (!ep_in_empty && n < 10) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (ep_in_data !== e) begin
                n_bad++; $display("FAIL urst_data[%0d]: got %h expected %h", n, ep_in_data, e);
            end
            ep_in_re = 1'b1; tick(); n++;
        end
        ep_in_re = 1'b0;
        n_cmp++;
        if (ep_in_empty !== 1'b0 || in_level !== 8'd30) begin
            n_bad++; $display("FAIL urst_pre: got empty=%b level=%0d expected 0/30", ep_in_empty, in_level);
        end
        usb_rst = 1'b1; in_valid = 1'b1; ep_in_re = 1'b1; ep_out_we = 1'b1;
        tick();
        usb_rst = 1'b0; in_valid = 1'b0; ep_in_re = 1'b0; ep_out_we = 1'b0;
        exp_q.delete();
        n_cmp++;
        if (in_level !== 8'd0 || out_level !== 8'd0 || ep_in_empty !== 1'b1 || unf_err !== 1'b0) begin
            n_bad++; $display("FAIL urst_clear: got in=%0d out=%0d empty=%b unf=%b expected 0/0/1/0",
                in_level, out_level, ep_in_empty, unf_err);
        end
        in_flush = 1'b1; tick(); in_flush = 1'b0; tick();
        n_cmp++;
        if (ep_in_empty !== 1'b1) begin
            n_bad++; $display("FAIL urst_hold: got empty=%b expected 1", ep_in_empty);
        end
        ep_in_re = 1'b1; err_clr = 1'b1; tick();
        ep_in_re = 1'b0;
        n_cmp++;
        if (unf_err !== 1'b1) begin
            n_bad++; $display("FAIL unf_wins_clr: got %b expected 1", unf_err);
        end
        tick(); err_clr = 1'b0;
        n_cmp++;
        if (unf_err !== 1'b0) begin
            n_bad++; $display("FAIL unf_clr: got %b expected 0", unf_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_out_overflow();
        test_usb_rst();
        n_cmp++;
        if (exp_q.size() !== 0 || out_q.size() !== 0) begin
            n_bad++; $display("FAIL scoreboard_left: got %0d/%0d entries expected 0/0", exp_q.size(), out_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
